// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction sequencer for an external combinational 1-bit full-subtractor cell.
// Operands are shifted out LSB-first; the cell's borrow is registered and fed back next bit.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_in_i,
    input  logic [WIDTH-1:0] b_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_out_o,
    output logic             borrow_out_o,
    output logic             fs_a_o,
    output logic             fs_b_o,
    output logic             fs_cin_o,
    input  logic             fs_diff_i,
    input  logic             fs_borrow_i
);

    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        fs_a_o   = 1'b0;
        fs_b_o   = 1'b0;
        fs_cin_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StShift;
                    a_d      = a_in_i;
                    b_d      = b_in_i;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            StShift: begin
                busy_o   = 1'b1;
                fs_a_o   = a_q[0];
                fs_b_o   = b_q[0];
                fs_cin_o = borrow_q;
                // Difference bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
                res_d    = WIDTH'({fs_diff_i, res_q} >> 1);
                borrow_d = fs_borrow_i;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    diff_d  = res_d;
                    bout_d  = fs_borrow_i;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign diff_out_o   = diff_q;
    assign borrow_out_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl at WIDTH 8, 1 and 16, each driving an ideal full-subtractor cell.
// Results are compared against plain modular arithmetic on the accepted operands.
module tb_serial_subtractor_ctrl;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0] start_s;
    logic [15:0]   a_s [NI];
    logic [15:0]   b_s [NI];
    wire  [NI-1:0] busy_s, done_s, bor_s, fa_s, fb_s, fc_s;
    wire  [NI-1:0] fd_s, fbo_s;
    logic [15:0]   diff_s [NI];
    wire  [7:0]    diff8;
    wire  [0:0]    diff1;
    wire  [15:0]   diff16;

    // Ideal combinational full-subtractor cells.
    assign fd_s  = fa_s ^ fb_s ^ fc_s;
    assign fbo_s = (~fa_s & fb_s) | (~(fa_s ^ fb_s) & fc_s);

    always_comb begin
        diff_s[0] = {8'h00, diff8};
        diff_s[1] = {15'h0000, diff1};
        diff_s[2] = diff16;
    end

    serial_subtractor_ctrl #(.WIDTH(8)) u_w8 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[0]),
        .a_in_i(a_s[0][7:0]), .b_in_i(b_s[0][7:0]),
        .busy_o(busy_s[0]), .done_o(done_s[0]), .diff_out_o(diff8), .borrow_out_o(bor_s[0]),
        .fs_a_o(fa_s[0]), .fs_b_o(fb_s[0]), .fs_cin_o(fc_s[0]),
        .fs_diff_i(fd_s[0]), .fs_borrow_i(fbo_s[0])
    );

    serial_subtractor_ctrl #(.WIDTH(1)) u_w1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[1]),
        .a_in_i(a_s[1][0:0]), .b_in_i(b_s[1][0:0]),
        .busy_o(busy_s[1]), .done_o(done_s[1]), .diff_out_o(diff1), .borrow_out_o(bor_s[1]),
        .fs_a_o(fa_s[1]), .fs_b_o(fb_s[1]), .fs_cin_o(fc_s[1]),
        .fs_diff_i(fd_s[1]), .fs_borrow_i(fbo_s[1])
    );

    serial_subtractor_ctrl #(.WIDTH(16)) u_w16 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s[2]),
        .a_in_i(a_s[2]), .b_in_i(b_s[2]),
        .busy_o(busy_s[2]), .done_o(done_s[2]), .diff_out_o(diff16), .borrow_out_o(bor_s[2]),
        .fs_a_o(fa_s[2]), .fs_b_o(fb_s[2]), .fs_cin_o(fc_s[2]),
        .fs_diff_i(fd_s[2]), .fs_borrow_i(fbo_s[2])
    );

    int          n_checks;
    int          n_errors;
    logic [15:0] held_diff [NI];
    logic        held_bor  [NI];

    function automatic int w_of(int i);
        case (i)
            0:       return 8;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(int i);
        check_eq("rst_busy", 32'(busy_s[i]), 0);
        check_eq("rst_done", 32'(done_s[i]), 0);
        check_eq("rst_diff", 32'(diff_s[i]), 0);
        check_eq("rst_borrow", 32'(bor_s[i]), 0);
        check_eq("rst_fs", 32'({fa_s[i], fb_s[i], fc_s[i]}), 0);
    endtask

    // One operation on instance i; optionally pulses a stray start at cycle poke.
    task automatic run_op(int i, logic [15:0] a, logic [15:0] b, int poke);
        int          w;
        int          cyc;
        int          busy_cnt;
        logic [31:0] mask, lo, ac, bc, exp_d;
        logic        exp_b;
        w     = w_of(i);
        mask  = (32'h1 << w) - 1;
        ac    = {16'h0, a} & mask;
        bc    = {16'h0, b} & mask;
        exp_d = (ac - bc) & mask;
        exp_b = (ac < bc);

        @(negedge clk);
        check_eq("done_single", 32'(done_s[i]), 0);
        start_s[i] = 1'b1;
        a_s[i]     = a;
        b_s[i]     = b;
        @(negedge clk);
        start_s[i] = 1'b0;
        a_s[i]     = 16'($urandom);
        b_s[i]     = 16'($urandom);
        cyc        = 1;
        busy_cnt   = 0;
        while (!done_s[i] && cyc <= w + 5) begin
            busy_cnt += int'(busy_s[i]);
            if (cyc <= w) begin
                lo = (32'h1 << (cyc - 1)) - 1;
                check_eq("fs_a", 32'(fa_s[i]), 32'(ac[cyc-1]));
                check_eq("fs_b", 32'(fb_s[i]), 32'(bc[cyc-1]));
                check_eq("fs_cin", 32'(fc_s[i]), 32'((ac & lo) < (bc & lo)));
                check_eq("diff_hold", 32'(diff_s[i]), 32'(held_diff[i]));
                check_eq("borrow_hold", 32'(bor_s[i]), 32'(held_bor[i]));
            end
            if (cyc == poke) begin
                start_s[i] = 1'b1;
                a_s[i]     = 16'($urandom);
                b_s[i]     = 16'($urandom);
            end else begin
                start_s[i] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_s[i] = 1'b0;
        busy_cnt += int'(busy_s[i]);
        check_eq("latency", 32'(cyc), 32'(w + 1));
        check_eq("busy_cycles", 32'(busy_cnt), 32'(w + 1));
        check_eq("diff", 32'(diff_s[i]), exp_d);
        check_eq("borrow", 32'(bor_s[i]), 32'(exp_b));
        check_eq("fs_zero_done", 32'({fa_s[i], fb_s[i], fc_s[i]}), 0);
        held_diff[i] = exp_d[15:0];
        held_bor[i]  = exp_b;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start_s  = '0;
        for (int i = 0; i < NI; i++) begin
            a_s[i]       = '0;
            b_s[i]       = '0;
            held_diff[i] = '0;
            held_bor[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_reset_state(i);
        rst = 1'b0;

        // Directed WIDTH=8 cases, issued back-to-back.
        run_op(0, 16'h005A, 16'h003C, 0);
        run_op(0, 16'h0010, 16'h0020, 0);
        run_op(0, 16'h0000, 16'h0001, 0);
        run_op(0, 16'h0077, 16'h0077, 0);
        run_op(0, 16'h00FF, 16'h0000, 0);

        // Stray start three cycles into an operation must be dropped.
        run_op(0, 16'h00C3, 16'h0045, 3);
        repeat (12) begin
            @(negedge clk);
            check_eq("no_extra_done", 32'(done_s[0]), 0);
        end
        check_eq("idle_after_ignore", 32'(busy_s[0]), 0);

        // Reset during SHIFT cycle 4.
        @(negedge clk);
        start_s[0] = 1'b1;
        a_s[0]     = 16'h009D;
        b_s[0]     = 16'h002B;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("busy_before_rst", 32'(busy_s[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0);
        for (int i = 0; i < NI; i++) begin
            held_diff[i] = '0;
            held_bor[i]  = 1'b0;
        end
        run_op(0, 16'h009D, 16'h002B, 0);

        for (int k = 0; k < 20; k++) run_op(0, 16'($urandom), 16'($urandom), 0);

        // WIDTH=1 exhaustive.
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) run_op(1, 16'(a), 16'(b), 0);

        // WIDTH=16 corners then random.
        run_op(2, 16'hFFFF, 16'h0000, 0);
        run_op(2, 16'h0000, 16'hFFFF, 0);
        run_op(2, 16'h8000, 16'h8001, 0);
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            run_op(2, 16'($urandom), 16'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
